// File: rtl/fpu_bcd_out_if.sv
// Request/result bundle for the FPU-result-to-BCD converter.
// The master drives start/in_e/in_m; the converter (slave) drives the digits and status.
interface fpu_bcd_out_if #(parameter int FRAC_DIGITS = 2);
  logic                       start;
  logic [6:0]                 in_e;
  logic [14:0]                in_m;
  logic [19:0]                int_bcd;
  logic [4*FRAC_DIGITS-1:0]   frac_bcd;
  logic                       ovf;
  logic                       out_valid;
  logic                       idle;

  modport master (
    output start, in_e, in_m,
    input  int_bcd, frac_bcd, ovf, out_valid, idle
  );

  modport slave (
    input  start, in_e, in_m,
    output int_bcd, frac_bcd, ovf, out_valid, idle
  );
endinterface

// File: rtl/fpu_bcd_out.sv
// FPU result (7b exp, 1.14 mantissa) to 5 integer + FRAC_DIGITS fraction BCD digits; out_valid 18+FRAC_DIGITS cycles after accept.
// FPU_BCD_ROUND_EN: one extra fraction digit + ROUND state (round half up), latency 20+FRAC_DIGITS; start ignored unless idle.
module fpu_bcd_out #(
  parameter int FRAC_DIGITS = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  fpu_bcd_out_if.slave  bus
);

`ifdef FPU_BCD_ROUND_EN
  localparam int NDIG = FRAC_DIGITS + 1;
`else
  localparam int NDIG = FRAC_DIGITS;
`endif
  localparam int FW = 4 * NDIG;
  localparam logic [4:0] FRAC_LAST = 5'(NDIG - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ALIGN  = 3'd1;
  localparam logic [2:0] S_DABBLE = 3'd2;
  localparam logic [2:0] S_FRAC   = 3'd3;
`ifdef FPU_BCD_ROUND_EN
  localparam logic [2:0] S_ROUND  = 3'd4;
`endif
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]                 state;
  logic [6:0]                 e_r;
  logic [14:0]                m_r;
  logic [15:0]                x_int;
  logic [13:0]                f;
  logic [19:0]                bcd_acc;
  logic [FW-1:0]              frac_acc;
  logic                       ovf_int;
  logic [4:0]                 cnt;
  logic [19:0]                int_bcd_q;
  logic [4*FRAC_DIGITS-1:0]   frac_bcd_q;
  logic                       ovf_q;
  logic                       out_valid_q;

  function automatic logic [19:0] dd_step(input logic [19:0] b, input logic bin);
    logic [19:0] t;
    t = b;
    for (int i = 0; i < 5; i++)
      if (t[4*i +: 4] >= 4'd5) t[4*i +: 4] = t[4*i +: 4] + 4'd3;
    return {t[18:0], bin};
  endfunction

  // Float-to-fixed alignment: X holds 16 integer and 14 fraction bits.
  logic [29:0] x_algn;
  logic        ovf_algn;
  logic [7:0]  rsh;

  always_comb begin
    x_algn   = '0;
    ovf_algn = 1'b0;
    rsh      = 8'd0 - {e_r[6], e_r};
    if (m_r != 15'd0) begin
      if (!e_r[6]) begin
        if (e_r >= 7'd16) ovf_algn = 1'b1;
        else              x_algn   = {15'd0, m_r} << e_r[3:0];
      end else if (rsh < 8'd15) begin
        x_algn = {15'd0, m_r} >> rsh[3:0];
      end
    end
  end

  // Fraction digit extraction: multiply by ten, the carry-out nibble is the next digit.
  logic [17:0]   f18;
  logic [FW-1:0] frac_next;

  always_comb begin
    f18            = ({4'd0, f} << 3) + ({4'd0, f} << 1);
    frac_next      = frac_acc << 4;
    frac_next[3:0] = f18[17:14];
  end

`ifdef FPU_BCD_ROUND_EN
  localparam int SW = 20 + 4 * FRAC_DIGITS;

  function automatic logic [SW:0] bcd_inc(input logic [SW-1:0] s);
    logic [SW-1:0] r;
    logic          c;
    r = s;
    c = 1'b1;
    for (int i = 0; i < SW / 4; i++) begin
      if (c) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return {c, r};
  endfunction

  logic [SW-1:0] rstr;
  logic [SW:0]   rinc;
  logic          rup;
  logic          rovf;
  logic [SW-1:0] rres;

  // Low nibble of frac_acc is the rounding digit; it is never shown.
  always_comb begin
    rstr = {bcd_acc, frac_acc[FW-1:4]};
    rinc = bcd_inc(rstr);
    rup  = (frac_acc[3:0] >= 4'd5);
    rovf = ovf_int | (rup & rinc[SW]);
    rres = rup ? rinc[SW-1:0] : rstr;
    if (rovf) rres = '0;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      e_r         <= '0;
      m_r         <= '0;
      x_int       <= '0;
      f           <= '0;
      bcd_acc     <= '0;
      frac_acc    <= '0;
      ovf_int     <= 1'b0;
      cnt         <= '0;
      int_bcd_q   <= '0;
      frac_bcd_q  <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            e_r   <= bus.in_e;
            m_r   <= bus.in_m;
            state <= S_ALIGN;
          end
        end
        S_ALIGN: begin
          x_int    <= x_algn[29:14];
          f        <= x_algn[13:0];
          ovf_int  <= ovf_algn;
          bcd_acc  <= '0;
          frac_acc <= '0;
          cnt      <= '0;
          state    <= S_DABBLE;
        end
        S_DABBLE: begin
          bcd_acc <= dd_step(bcd_acc, x_int[15]);
          x_int   <= {x_int[14:0], 1'b0};
          cnt     <= cnt + 5'd1;
          if (cnt == 5'd15) begin
            cnt   <= '0;
            state <= S_FRAC;
          end
        end
        S_FRAC: begin
          f        <= f18[13:0];
          frac_acc <= frac_next;
          cnt      <= cnt + 5'd1;
          if (cnt == FRAC_LAST) begin
            cnt <= '0;
`ifdef FPU_BCD_ROUND_EN
            state <= S_ROUND;
`else
            // Results land on the DONE entry edge so out_valid and data align.
            int_bcd_q   <= ovf_int ? 20'd0 : bcd_acc;
            frac_bcd_q  <= ovf_int ? '0 : frac_next;
            ovf_q       <= ovf_int;
            out_valid_q <= 1'b1;
            state       <= S_DONE;
`endif
          end
        end
`ifdef FPU_BCD_ROUND_EN
        S_ROUND: begin
          int_bcd_q   <= rres[SW-1:SW-20];
          frac_bcd_q  <= rres[4*FRAC_DIGITS-1:0];
          ovf_q       <= rovf;
          out_valid_q <= 1'b1;
          state       <= S_DONE;
        end
`endif
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.int_bcd   = int_bcd_q;
  assign bus.frac_bcd  = frac_bcd_q;
  assign bus.ovf       = ovf_q;
  assign bus.out_valid = out_valid_q;
  assign bus.idle      = (state == S_IDLE);

endmodule

// File: tb/tb_fpu_bcd_out.sv
// Directed bench for fpu_bcd_out (FRAC_DIGITS=2): vector table plus stray-start and mid-conversion reset sequences.
module tb_fpu_bcd_out;
`ifdef FPU_BCD_ROUND_EN
  localparam int LAT = 22;
`else
  localparam int LAT = 20;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  fpu_bcd_out_if #(.FRAC_DIGITS(2)) bus ();
  fpu_bcd_out #(.FRAC_DIGITS(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  e;
    logic [14:0] m;
    logic [19:0] ib;
    logic [7:0]  fb;
    logic        ov;
    logic [19:0] ib_r;
    logic [7:0]  fb_r;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Accepts one request, then waits (bounded) for out_valid and checks data, latency and hold.
  task automatic run_conv(input int idx, input logic [6:0] e, input logic [14:0] m,
                          input logic [19:0] ib, input logic [7:0] fb, input logic ov,
                          input logic [19:0] prev_ib);
    int n;
    bit seen;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.in_e = e; bus.in_m = m;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n = 1; seen = 1'b0;
    chk($sformatf("v%0d idle_low", idx), {31'd0, bus.idle}, 32'd0);
    chk($sformatf("v%0d hold", idx), {12'd0, bus.int_bcd}, {12'd0, prev_ib});
    while (n < 60 && !seen) begin
      if (bus.out_valid) seen = 1'b1;
      else begin @(posedge clk); #1; n++; end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL v%0d timeout: got no out_valid expected one", idx);
    end else begin
      chk($sformatf("v%0d latency", idx), n, LAT);
      chk($sformatf("v%0d int", idx), {12'd0, bus.int_bcd}, {12'd0, ib});
      chk($sformatf("v%0d frac", idx), {24'd0, bus.frac_bcd}, {24'd0, fb});
      chk($sformatf("v%0d ovf", idx), {31'd0, bus.ovf}, {31'd0, ov});
      @(posedge clk); #1;
      chk($sformatf("v%0d pulse_width", idx), {31'd0, bus.out_valid}, 32'd0);
      chk($sformatf("v%0d idle_after", idx), {31'd0, bus.idle}, 32'd1);
    end
  endtask

  initial begin
    int n;
    int pulses;
    logic [19:0] prev;
    logic [19:0] ib;
    logic [7:0]  fb;

    checks = 0; errors = 0;
    bus.start = 1'b0; bus.in_e = '0; bus.in_m = '0;

    //           e       m        int       frac  ov  int_rnd   frac_rnd
    tbl[0]  = '{7'h00, 15'h4000, 20'h00001, 8'h00, 1'b0, 20'h00001, 8'h00};
    tbl[1]  = '{7'h03, 15'h5000, 20'h00010, 8'h00, 1'b0, 20'h00010, 8'h00};
    tbl[2]  = '{7'h7F, 15'h6000, 20'h00000, 8'h75, 1'b0, 20'h00000, 8'h75};
    tbl[3]  = '{7'h0F, 15'h7FFF, 20'h65534, 8'h00, 1'b0, 20'h65534, 8'h00};
    tbl[4]  = '{7'h10, 15'h4000, 20'h00000, 8'h00, 1'b1, 20'h00000, 8'h00};
    tbl[5]  = '{7'h05, 15'h0000, 20'h00000, 8'h00, 1'b0, 20'h00000, 8'h00};
    tbl[6]  = '{7'h6C, 15'h7FFF, 20'h00000, 8'h00, 1'b0, 20'h00000, 8'h00};
    tbl[7]  = '{7'h01, 15'h5FF8, 20'h00002, 8'h99, 1'b0, 20'h00003, 8'h00};
    tbl[8]  = '{7'h40, 15'h4000, 20'h00000, 8'h00, 1'b0, 20'h00000, 8'h00};
    tbl[9]  = '{7'h3F, 15'h4000, 20'h00000, 8'h00, 1'b1, 20'h00000, 8'h00};
    tbl[10] = '{7'h0A, 15'h7FFF, 20'h02047, 8'h93, 1'b0, 20'h02047, 8'h94};
    tbl[11] = '{7'h7F, 15'h4000, 20'h00000, 8'h50, 1'b0, 20'h00000, 8'h50};
    tbl[12] = '{7'h72, 15'h7FFF, 20'h00000, 8'h00, 1'b0, 20'h00000, 8'h00};
    tbl[13] = '{7'h71, 15'h7FFF, 20'h00000, 8'h00, 1'b0, 20'h00000, 8'h00};
    tbl[14] = '{7'h14, 15'h0000, 20'h00000, 8'h00, 1'b0, 20'h00000, 8'h00};

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst int", {12'd0, bus.int_bcd}, 32'd0);
    chk("rst frac", {24'd0, bus.frac_bcd}, 32'd0);
    chk("rst ovf", {31'd0, bus.ovf}, 32'd0);
    chk("rst out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst idle", {31'd0, bus.idle}, 32'd1);
    rst_n = 1'b1;

    prev = 20'h0;
    for (int i = 0; i < 15; i++) begin
`ifdef FPU_BCD_ROUND_EN
      ib = tbl[i].ib_r; fb = tbl[i].fb_r;
`else
      ib = tbl[i].ib; fb = tbl[i].fb;
`endif
      run_conv(i, tbl[i].e, tbl[i].m, ib, fb, tbl[i].ov, prev);
      prev = ib;
    end

    // Stray start during DABBLE and during DONE must not launch a second conversion.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.in_e = 7'h00; bus.in_m = 15'h4000;
    @(posedge clk); #1;
    bus.start = 1'b0;
    pulses = 0;
    for (n = 1; n <= 60; n++) begin
      if (n == 5) begin bus.start = 1'b1; bus.in_e = 7'h03; bus.in_m = 15'h5000; end
      if (n == 6) bus.start = 1'b0;
      if (bus.out_valid) begin
        pulses++;
        chk("stray int", {12'd0, bus.int_bcd}, 32'h00001);
        bus.start = 1'b1;
        @(posedge clk); #1;
        n++;
        bus.start = 1'b0;
        chk("stray idle_after_done", {31'd0, bus.idle}, 32'd1);
      end
      @(posedge clk); #1;
    end
    chk("stray pulses", pulses, 32'd1);

    // Reset five cycles into a conversion aborts it and clears outputs at once.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.in_e = 7'h03; bus.in_m = 15'h5000;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort int", {12'd0, bus.int_bcd}, 32'd0);
    chk("abort idle", {31'd0, bus.idle}, 32'd1);
    chk("abort out_valid", {31'd0, bus.out_valid}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    pulses = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (bus.out_valid) pulses++;
    end
    chk("abort no_valid", pulses, 32'd0);
    run_conv(100, 7'h7F, 15'h6000, 20'h00000, 8'h75, 1'b0, 20'h00000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
